// File: rtl/codebond_pkg.sv
// Shared types, constants and helpers for the Codebond round controller.
package codebond_pkg;

   localparam int DIGIT_W   = 2;
   localparam int NUM_SLOTS = 3;
   localparam int CODE_W    = DIGIT_W * NUM_SLOTS;

   // Encoding is visible on the debug/display state output.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ENTRY = 3'd2,
      CHECK = 3'd3,
      WIN   = 3'd4,
      LOSE  = 3'd5
   } state_t;

   // Two-digit BCD increment {tens, units}; units 9 rolls into tens.
   function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
      logic [7:0] res;
      res = bcd;
      if (bcd[3:0] == 4'd9) begin
         res[3:0] = 4'd0;
         res[7:4] = bcd[7:4] + 4'd1;
      end else begin
         res[3:0] = bcd[3:0] + 4'd1;
      end
      return res;
   endfunction

   // Map any LFSR digit value 3 onto 0 so every slot holds a symbol 0..2.
   function automatic logic [CODE_W-1:0] fold_code(input logic [CODE_W-1:0] raw);
      logic [CODE_W-1:0] res;
      res = raw;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (raw[i*DIGIT_W +: DIGIT_W] == 2'd3) res[i*DIGIT_W +: DIGIT_W] = '0;
      end
      return res;
   endfunction

endpackage

// File: rtl/codebond_btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector, N bits wide.
module codebond_btn_edge #(
   parameter int N = 1
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic [N-1:0] i_din,
   output logic [N-1:0] o_rise
);

   logic [N-1:0] r_meta;
   logic [N-1:0] r_sync;
   logic [N-1:0] r_prev;

   // Synchronise the asynchronous inputs and keep one cycle of history for edge detection.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_meta <= '0;
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample its old neighbour, forming a real pipeline.
         r_meta <= i_din;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/codebond_round_ctrl.sv
// Codebond round sequencer: latches the secret, collects guesses, checks them and runs the timer.
module codebond_round_ctrl
   import codebond_pkg::*;
#(
   parameter int TICK_DIV     = 50_000_000,
   parameter int TIME_LIMIT_S = 60,
   parameter int MAX_ATTEMPTS = 8
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       start,
   input  logic [5:0] rand_in,
   input  logic [2:0] btn,
   output logic [5:0] code,
   output logic [5:0] guess,
   output logic [2:0] slot_ok,
   output logic [1:0] slot_idx,
   output logic [3:0] secs_one,
   output logic [3:0] secs_ten,
   output logic [3:0] attempts,
   output logic [2:0] state,
   output logic       win,
   output logic       lose
);

   localparam int               PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
   localparam logic [7:0]       LIMIT_BCD = {4'(TIME_LIMIT_S / 10), 4'(TIME_LIMIT_S % 10)};
   localparam logic [3:0]       MAX_ATT   = 4'(MAX_ATTEMPTS);

   state_t               r_state;
   logic [CODE_W-1:0]    r_code;
   logic [CODE_W-1:0]    r_guess;
   logic [NUM_SLOTS-1:0] r_slot_ok;
   logic [1:0]           r_slot_idx;
   logic [3:0]           r_attempts;
   logic [7:0]           r_secs;
   logic [PRESC_W-1:0]   r_presc;

   state_t               w_state_nxt;
   logic [2:0]           w_btn_rise;
   logic [0:0]           w_start_rise;
   logic                 w_press;
   logic [1:0]           w_sym;
   logic                 w_count;
   logic                 w_tick;
   logic [7:0]           w_secs_nxt;
   logic                 w_timeout;
   logic [NUM_SLOTS-1:0] w_match;
   logic                 w_all_match;
   logic [3:0]           w_att_inc;

   codebond_btn_edge #(.N(3)) u_btn_edge (
      .clock  (clock),
      .resetn (resetn),
      .i_din  (btn),
      .o_rise (w_btn_rise)
   );

   codebond_btn_edge #(.N(1)) u_start_edge (
      .clock  (clock),
      .resetn (resetn),
      .i_din  (start),
      .o_rise (w_start_rise)
   );

   // A cycle with several button edges is discarded; a single edge names the symbol.
   assign w_press = $onehot(w_btn_rise);
   assign w_sym   = w_btn_rise[2] ? 2'd2 : (w_btn_rise[1] ? 2'd1 : 2'd0);

   assign w_count    = (r_state == ENTRY) || (r_state == CHECK);
   assign w_tick     = w_count && (r_presc == PRESC_MAX);
   assign w_secs_nxt = bcd_inc(r_secs);
   assign w_timeout  = w_tick && (w_secs_nxt == LIMIT_BCD);
   assign w_att_inc  = (r_attempts >= MAX_ATT) ? MAX_ATT : r_attempts + 4'd1;

   // Per-slot comparison of the current guess against the secret.
   always_comb begin
      w_match = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         w_match[i] = (r_guess[i*DIGIT_W +: DIGIT_W] == r_code[i*DIGIT_W +: DIGIT_W]);
      end
   end
   assign w_all_match = &w_match;

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic; a win found in CHECK beats a simultaneous timeout.
   always_comb begin
      // NOTE: assigning the default first means every path drives the output, so no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         IDLE:  if (w_start_rise[0]) w_state_nxt = LOAD;
         LOAD:  w_state_nxt = ENTRY;
         ENTRY: begin
            if (w_timeout)                         w_state_nxt = LOSE;
            else if (w_press && r_slot_idx == 2'd2) w_state_nxt = CHECK;
         end
         CHECK: begin
            if (w_all_match)                           w_state_nxt = WIN;
            else if (w_timeout || w_att_inc == MAX_ATT) w_state_nxt = LOSE;
            else                                       w_state_nxt = ENTRY;
         end
         WIN, LOSE: if (w_start_rise[0]) w_state_nxt = LOAD;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Secret, guess, match flags and attempt counter.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_code     <= '0;
         r_guess    <= '0;
         r_slot_ok  <= '0;
         r_slot_idx <= '0;
         r_attempts <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               r_code     <= fold_code(rand_in);
               r_guess    <= '0;
               r_slot_ok  <= '0;
               r_slot_idx <= '0;
               r_attempts <= '0;
            end
            ENTRY: begin
               if (w_press) begin
                  for (int i = 0; i < NUM_SLOTS; i++) begin
                     if (r_slot_idx == 2'(i)) r_guess[i*DIGIT_W +: DIGIT_W] <= w_sym;
                  end
                  r_slot_idx <= (r_slot_idx == 2'd2) ? 2'd0 : r_slot_idx + 2'd1;
               end
            end
            CHECK: begin
               r_slot_ok <= w_match;
               if (!w_all_match) r_attempts <= w_att_inc;
            end
            default: ;
         endcase
      end
   end

   // Prescaler and BCD seconds; they run only while a round is being played.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_presc <= '0;
         r_secs  <= '0;
      end else if (r_state == LOAD) begin
         r_presc <= '0;
         r_secs  <= '0;
      end else if (w_count) begin
         if (w_tick) begin
            r_presc <= '0;
            r_secs  <= w_secs_nxt;
         end else begin
            r_presc <= r_presc + PRESC_W'(1);
         end
      end
   end

   assign code     = r_code;
   assign guess    = r_guess;
   assign slot_ok  = r_slot_ok;
   assign slot_idx = r_slot_idx;
   assign secs_one = r_secs[3:0];
   assign secs_ten = r_secs[7:4];
   assign attempts = r_attempts;
   assign state    = r_state;
   assign win      = (r_state == WIN);
   assign lose     = (r_state == LOSE);

endmodule

// File: tb/tb_codebond_round_ctrl.sv
// Scoreboard bench for codebond_round_ctrl with a round-level reference model.
module tb_codebond_round_ctrl;
   import codebond_pkg::*;

   localparam int TICK_DIV     = 4;
   localparam int TIME_LIMIT_S = 10;
   localparam int MAX_ATTEMPTS = 2;

   logic       clock   = 1'b0;
   logic       resetn  = 1'b0;
   logic       start   = 1'b0;
   logic [5:0] rand_in = '0;
   logic [2:0] btn     = '0;

   logic [5:0] code, guess;
   logic [2:0] slot_ok;
   logic [1:0] slot_idx;
   logic [3:0] secs_one, secs_ten, attempts;
   logic [2:0] state;
   logic       win, lose;

   codebond_round_ctrl #(
      .TICK_DIV     (TICK_DIV),
      .TIME_LIMIT_S (TIME_LIMIT_S),
      .MAX_ATTEMPTS (MAX_ATTEMPTS)
   ) dut (
      .clock    (clock),
      .resetn   (resetn),
      .start    (start),
      .rand_in  (rand_in),
      .btn      (btn),
      .code     (code),
      .guess    (guess),
      .slot_ok  (slot_ok),
      .slot_idx (slot_idx),
      .secs_one (secs_one),
      .secs_ten (secs_ten),
      .attempts (attempts),
      .state    (state),
      .win      (win),
      .lose     (lose)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [5:0] guess;
      logic [2:0] slot_ok;
      logic [3:0] attempts;
      logic [2:0] st;
   } chk_t;

   int         n_pass  = 0;
   int         n_total = 0;
   int         cycle   = 0;
   bit         secs_watch = 1'b0;
   logic [5:0] q_code[$];
   chk_t       q_chk[$];
   logic [7:0] q_secs[$];

   logic [5:0] m_code;
   int         m_att;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference rules: digit 3 reads as 0; a slot matches when its symbols are equal.
   function automatic logic [5:0] fold(input logic [5:0] raw);
      logic [5:0] r;
      for (int i = 0; i < 3; i++) begin
         logic [1:0] d;
         d = raw[2*i +: 2];
         r[2*i +: 2] = (d == 2'd3) ? 2'd0 : d;
      end
      return r;
   endfunction

   function automatic logic [2:0] model_slots(input logic [5:0] c, input logic [5:0] g);
      logic [2:0] r;
      for (int i = 0; i < 3; i++) r[i] = (c[2*i +: 2] == g[2*i +: 2]);
      return r;
   endfunction

   // Monitor: pops expectations whenever the DUT presents a round start, a check result or a new second.
   initial begin : monitor
      logic [2:0] prev_st;
      logic [7:0] prev_secs, cur_secs, e_secs;
      logic [5:0] e_code;
      chk_t       e_chk;
      int         last_mark;
      prev_st = IDLE; prev_secs = '0; last_mark = 0;
      forever begin
         @(negedge clock);
         cycle++;
         cur_secs = {secs_ten, secs_one};
         if (!resetn) begin
            prev_st = IDLE;
            prev_secs = '0;
         end else begin
            if (prev_st == LOAD && state == ENTRY) begin
               last_mark = cycle;
               check("round_expected", 32'(q_code.size() > 0), 1);
               if (q_code.size() > 0) begin
                  e_code = q_code.pop_front();
                  check("round_code", 32'(code), 32'(e_code));
                  check("round_guess", 32'(guess), 0);
                  check("round_slot_ok", 32'(slot_ok), 0);
                  check("round_slot_idx", 32'(slot_idx), 0);
                  check("round_secs", 32'(cur_secs), 0);
                  check("round_attempts", 32'(attempts), 0);
               end
            end
            if (prev_st == CHECK) begin
               check("chk_expected", 32'(q_chk.size() > 0), 1);
               if (q_chk.size() > 0) begin
                  e_chk = q_chk.pop_front();
                  check("chk_guess", 32'(guess), 32'(e_chk.guess));
                  check("chk_slot_ok", 32'(slot_ok), 32'(e_chk.slot_ok));
                  check("chk_attempts", 32'(attempts), 32'(e_chk.attempts));
                  check("chk_state", 32'(state), 32'(e_chk.st));
                  check("chk_slot_idx", 32'(slot_idx), 0);
                  check("chk_win", 32'(win), 32'(e_chk.st == WIN));
                  check("chk_lose", 32'(lose), 32'(e_chk.st == LOSE));
               end
            end
            if (secs_watch && cur_secs != prev_secs && cur_secs != 8'h00) begin
               check("secs_expected", 32'(q_secs.size() > 0), 1);
               if (q_secs.size() > 0) begin
                  e_secs = q_secs.pop_front();
                  check("secs_value", 32'(cur_secs), 32'(e_secs));
                  check("secs_period", 32'(cycle - last_mark), 32'(TICK_DIV));
               end
            end
            if (cur_secs != prev_secs) last_mark = cycle;
            prev_st = state;
            prev_secs = cur_secs;
         end
      end
   end

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int n = 0;
      while (state !== s && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(name, 32'(state), 32'(s));
   endtask

   task automatic press(input logic [2:0] b, input int extra);
      btn = b;
      @(negedge clock);
      btn = 3'b000;
      repeat (2 + extra) @(negedge clock);
   endtask

   task automatic new_round(input logic [5:0] raw);
      rand_in = raw;
      m_code = fold(raw);
      m_att = 0;
      q_code.push_back(m_code);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      wait_state(ENTRY, 12, "enter_round");
   endtask

   // Enter one full guess and queue what the model predicts for its CHECK.
   task automatic do_guess(input logic [5:0] g, output logic [2:0] outcome);
      chk_t       e;
      logic [2:0] ok;
      logic [2:0] b;
      ok = model_slots(m_code, g);
      if (ok == 3'b111) begin
         outcome = WIN;
      end else begin
         m_att++;
         outcome = (m_att == MAX_ATTEMPTS) ? LOSE : ENTRY;
      end
      e.guess = g; e.slot_ok = ok; e.attempts = 4'(m_att); e.st = outcome;
      q_chk.push_back(e);
      for (int i = 0; i < 3; i++) begin
         b = 3'b000;
         b[g[2*i +: 2]] = 1'b1;
         press(b, int'($urandom_range(0, 1)));
      end
      if (outcome != ENTRY) wait_state(outcome, 10, "guess_outcome");
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [2:0] res;
      logic [5:0] g;

      // Reset state.
      repeat (3) @(negedge clock);
      check("rst_state", 32'(state), 32'(IDLE));
      check("rst_code", 32'(code), 0);
      check("rst_secs", 32'({secs_ten, secs_one}), 0);
      check("rst_flags", 32'({win, lose}), 0);
      resetn = 1'b1;
      repeat (2) @(negedge clock);

      // Correct guess wins; a mid-round start is ignored; timer and buttons frozen afterwards.
      new_round(6'b10_01_00);
      m_att = 0;
      q_chk.push_back('{guess: 6'b10_01_00, slot_ok: 3'b111, attempts: 4'd0, st: WIN});
      press(3'b001, 2);
      start = 1'b1; @(negedge clock); start = 1'b0;
      press(3'b010, 1);
      press(3'b100, 2);
      wait_state(WIN, 10, "win_reached");
      secs_watch = 1'b1;
      press(3'b001, 2);
      repeat (10) @(negedge clock);
      check("win_hold_guess", 32'(guess), 32'(6'b10_01_00));
      check("win_hold_state", 32'(state), 32'(WIN));
      check("win_flag", 32'(win), 1);
      secs_watch = 1'b0;

      // Two wrong guesses exhaust the attempts.
      new_round(6'b10_01_00);
      do_guess(6'b00_00_00, res);
      do_guess(6'b00_00_00, res);
      check("attempts_lose", 32'(lose), 1);

      // Timeout with no presses: seconds advance every TICK_DIV cycles and hold at the limit.
      secs_watch = 1'b1;
      for (int s = 1; s <= TIME_LIMIT_S; s++) q_secs.push_back({4'(s / 10), 4'(s % 10)});
      new_round(6'($urandom));
      wait_state(LOSE, 80, "timeout_lose");
      repeat (12) @(negedge clock);
      check("timeout_secs_hold", 32'({secs_ten, secs_one}), 32'h10);
      check("timeout_lose_flag", 32'(lose), 1);
      check("timeout_attempts", 32'(attempts), 0);
      secs_watch = 1'b0;

      // Digit 3 folds to 0; simultaneous button edges are ignored.
      new_round(6'b11_10_11);
      press(3'b011, 2);
      check("multi_press_idx", 32'(slot_idx), 0);
      check("multi_press_guess", 32'(guess), 0);

      // Asynchronous reset in the middle of entry.
      press(3'b010, 1);
      press(3'b100, 1);
      check("pre_rst_idx", 32'(slot_idx), 2);
      check("pre_rst_guess", 32'(guess), 32'(6'b00_10_01));
      #2 resetn = 1'b0;
      #1;
      check("async_rst_state", 32'(state), 32'(IDLE));
      check("async_rst_vals", 32'({code, guess, slot_ok, slot_idx, attempts}), 0);
      check("async_rst_secs", 32'({secs_ten, secs_one}), 0);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);

      // Randomised rounds against the model.
      for (int r = 0; r < 10; r++) begin
         new_round(6'($urandom));
         res = ENTRY;
         while (res == ENTRY) begin
            for (int i = 0; i < 3; i++) begin
               if ($urandom_range(0, 99) < 60) g[2*i +: 2] = m_code[2*i +: 2];
               else                            g[2*i +: 2] = 2'($urandom_range(0, 2));
            end
            do_guess(g, res);
         end
         repeat (2) @(negedge clock);
      end

      repeat (4) @(negedge clock);
      check("q_code_drained", 32'(q_code.size()), 0);
      check("q_chk_drained", 32'(q_chk.size()), 0);
      check("q_secs_drained", 32'(q_secs.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
